// File: rtl/conv_tile_sched.sv
// Convolution tile scheduler: accepts a job, configures the PE once, launches
// one tile per output-buffer slot, drains the PE and reports completion.
module conv_tile_sched #(
  parameter int WDOG_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_ci,
  input  logic [1:0] cfg_co,
  input  logic [7:0] cfg_tiles,
  input  logic       obuf_ready,
  input  logic       abort,
  input  logic       pe_last,
  input  logic       pe_end,
  output logic [1:0] pe_ci,
  output logic [1:0] pe_co,
  output logic       start_conv,
  output logic       start_again,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] tile_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Expiry fires on the edge where the counter would reach WDOG_MAX.
  localparam logic [9:0] WDOG_LAST = 10'(WDOG_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] tiles_q, tiles_d;
  logic [7:0] tile_cnt_q, tile_cnt_d;
  logic [9:0] wdog_q, wdog_d;
  logic [1:0] ci_q, ci_d;
  logic [1:0] co_q, co_d;
  logic       err_q, err_d;
  logic       cfg_ready_q, cfg_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       start_conv_q, start_conv_d;
  logic       start_again_q, start_again_d;
  logic       in_wdog_s;
  logic       in_wdog_next_s;
  logic       wdog_exp_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d        = state_q;
    tiles_d        = tiles_q;
    tile_cnt_d     = tile_cnt_q;
    ci_d           = ci_q;
    co_d           = co_q;
    err_d          = err_q;
    wdog_d         = 10'd0;
    in_wdog_s      = (state_q == RUN) || (state_q == DRAIN);
    wdog_exp_s     = in_wdog_s && (wdog_q == WDOG_LAST);

    if (abort && (state_q != IDLE)) begin
      // Abort outranks any PE pulse or watchdog expiry in the same cycle.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid && cfg_ready_q) begin
            ci_d       = cfg_ci;
            co_d       = cfg_co;
            tiles_d    = cfg_tiles;
            tile_cnt_d = 8'd0;
            err_d      = 1'b0;
            state_d    = (cfg_tiles == 8'd0) ? DONE : CONFIG;
          end else begin
            state_d = IDLE;
          end
        end
        CONFIG: state_d = LAUNCH;
        LAUNCH: begin
          if (obuf_ready) begin
            state_d = RUN;
          end else begin
            state_d = LAUNCH;
          end
        end
        RUN: begin
          if (pe_last && (tile_cnt_q != tiles_q)) begin
            tile_cnt_d = tile_cnt_q + 8'd1;
            state_d    = (tile_cnt_d == tiles_q) ? DRAIN : LAUNCH;
          end else if (wdog_exp_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          if (pe_end) begin
            state_d = DONE;
          end else if (wdog_exp_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    in_wdog_next_s = (state_d == RUN) || (state_d == DRAIN);
    if (in_wdog_next_s && (state_d != state_q)) begin
      wdog_d = 10'd0;
    end else if (in_wdog_s && in_wdog_next_s) begin
      wdog_d = wdog_q + 10'd1;
    end else begin
      wdog_d = 10'd0;
    end

    cfg_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    done_d        = (state_q == DONE) && !abort;
    start_conv_d  = (state_d == CONFIG) && (state_q != CONFIG);
    start_again_d = ((state_q == LAUNCH) && (state_d == RUN)) ||
                    ((state_q == RUN) && (state_d == DRAIN));
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tiles_q       <= 8'd0;
      tile_cnt_q    <= 8'd0;
      wdog_q        <= 10'd0;
      ci_q          <= 2'd0;
      co_q          <= 2'd0;
      err_q         <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_conv_q  <= 1'b0;
      start_again_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tiles_q       <= tiles_d;
      tile_cnt_q    <= tile_cnt_d;
      wdog_q        <= wdog_d;
      ci_q          <= ci_d;
      co_q          <= co_d;
      err_q         <= err_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_conv_q  <= start_conv_d;
      start_again_q <= start_again_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign start_conv  = start_conv_q;
  assign start_again = start_again_q;
  assign tile_cnt    = tile_cnt_q;
  assign pe_ci       = ci_q;
  assign pe_co       = co_q;

endmodule

// File: doc/conv_tile_sched.md
CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose these ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  scheduler can accept a job
- cfg_ci  in  2  input-channel code
- cfg_co  in  2  output-channel code
- cfg_tiles  in  8  tile count per job
- obuf_ready  in  1  output buffer can absorb one tile
- abort  in  1  synchronous job cancel
- pe_last  in  1  PE last-channel output pulse; marks tile complete
- pe_end  in  1  PE end-of-convolution pulse
- pe_ci  out  2  latched cfg_ci, to PE
- pe_co  out  2  latched cfg_co, to PE
- start_conv  out  1  one-cycle PE configure pulse
- start_again  out  1  one-cycle PE tile-launch pulse
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky watchdog error
- tile_cnt  out  8  tiles completed in the current job
REQ-003 SHALL provide parameter WDOG_MAX, default 1023, meaning the maximum cycles to wait for a PE pulse.

Function
REQ-004 SHALL register all outputs; no combinational path from input to output.
REQ-005 SHALL implement states IDLE, CONFIG, LAUNCH, RUN, DRAIN and DONE.
REQ-006 In IDLE, cfg_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 On cfg_valid&cfg_ready, SHALL latch cfg_ci, cfg_co and cfg_tiles, clear tile_cnt and err, and set busy the next cycle.
REQ-008 If the latched tile count is 0, SHALL go IDLE->DONE directly, with no start_conv and no start_again.
REQ-009 Otherwise SHALL go IDLE->CONFIG; start_conv SHALL be 1 for exactly the first CONFIG cycle, then the FSM SHALL go CONFIG->LAUNCH.
REQ-010 In LAUNCH, SHALL hold while obuf_ready=0; with obuf_ready=1, SHALL pulse start_again for one cycle and go to RUN.
REQ-011 In RUN, pe_last=1 SHALL increment tile_cnt. If the new tile_cnt equals the tile count, SHALL go to DRAIN; otherwise SHALL go to LAUNCH.
REQ-012 SHALL ignore pe_last outside RUN; tile_cnt SHALL never exceed the tile count.
REQ-013 On entering DRAIN, SHALL pulse start_again for one cycle, then wait for pe_end=1 and go DRAIN->DONE.
REQ-014 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL fall; the next state SHALL be IDLE.
REQ-015 SHALL run a 10-bit watchdog: cleared on each RUN/DRAIN entry, incremented each cycle in RUN/DRAIN.
REQ-016 When the watchdog reaches WDOG_MAX, SHALL set err=1 and go to IDLE with no done pulse.
REQ-017 err SHALL stay set until the next accepted job or reset.
REQ-018 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear busy and suppress done.
REQ-019 When abort coincides with pe_last, pe_end or a watchdog expiry, abort SHALL win; tile_cnt SHALL keep its pre-abort value.
REQ-020 start_conv and start_again SHALL never be high in the same cycle.
REQ-021 pe_ci and pe_co SHALL stay stable from CONFIG until the next accepted job.

Reset
REQ-022 While rst_n=0, SHALL set state IDLE and drive all outputs to 0 except cfg_ready=1; all counters SHALL be 0.
REQ-023 Reset asserted mid-job SHALL abandon the job without a done pulse; the first job after deassertion SHALL behave as from power-up.

Verification
REQ-024 Job ci=1, co=0, tiles=3, obuf_ready=1, pe_last 20 cycles after each start_again, pe_end 5 cycles after the 4th start_again -> 1 start_conv, 4 start_again, tile_cnt=3, 1 done, err=0.
REQ-025 tiles=0 -> done 2 cycles after the handshake, no start_conv or start_again, busy high 1 cycle.
REQ-026 obuf_ready=0 for 50 cycles in LAUNCH -> no start_again until the cycle after obuf_ready rises.
REQ-027 No pe_last after start_again -> err=1 and IDLE after 1023 RUN cycles, no done; a new job clears err.
REQ-028 abort in the same cycle as the 2nd pe_last (tiles=4) -> IDLE next cycle, tile_cnt=1, no done, cfg_ready=1.
REQ-029 rst_n low for 1 cycle during DRAIN -> all outputs at reset values; a new job completes normally.
